// File: rtl/seq_pkg.sv
// seq_pkg: sequencer state type, opcode constants and opcode decode helpers
// shared by the instruction_sequencer RTL.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam logic [5:0] OP_HALT    = 6'b111111;
    localparam logic [1:0] JMP_PREFIX = 2'b10;

    // HALT stops the program without reaching the decoder.
    function automatic logic is_halt(input logic [5:0] op);
        return op == OP_HALT;
    endfunction

    // JMP is consumed by the sequencer; its target lives in bits [3:0].
    function automatic logic is_jmp(input logic [5:0] op);
        return op[5:4] == JMP_PREFIX;
    endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if: valid/ready instruction channel from the
// sequencer (master) to the decoder (slave).
interface instruction_sequencer_if #(
    parameter int INSTR_W = 6
);
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output instruction,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instruction,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/prog_mem.sv
// prog_mem: program storage with one write port and a registered read port.
// The read register only updates when a fetch is requested, so the word
// being issued stays put while the decoder stalls.
module prog_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Program write port.
    // NOTE: the storage array has no reset so a loaded program survives rst_n; only the read register below is reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read, captured only on a fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetches words from prog_mem and issues them to a
// decoder over a valid/ready channel. HALT and JMP are consumed locally.
// Optional feature: define ISSUE_CNT_EN to add a saturating 16-bit
// issue_count output that counts decoder transfers.
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int INSTR_W    = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          halt_req,
    input  logic                          load_en,
    input  logic [$clog2(PROG_DEPTH)-1:0] load_addr,
    input  logic [INSTR_W-1:0]            load_data,
    instruction_sequencer_if.master       dec,
    output logic [$clog2(PROG_DEPTH)-1:0] pc,
    output logic                          busy,
    output logic                          done
`ifdef ISSUE_CNT_EN
    ,
    output logic [15:0]                   issue_count
`endif
);
    localparam int AW = $clog2(PROG_DEPTH);

    seq_state_e         r_state;
    seq_state_e         w_state_next;
    logic [AW-1:0]      r_pc;
    logic [AW-1:0]      w_pc_next;
    logic [AW-1:0]      w_jmp_target;
    logic [INSTR_W-1:0] w_rd_data;
    logic               w_is_halt;
    logic               w_is_jmp;
    logic               w_idle_like;
    logic               w_start_go;
    logic               w_load_ok;
    logic               w_fetch;
    logic               w_valid;
    logic               w_xfer;

    // Opcode decode of the word fetched into the read register.
    assign w_is_halt    = is_halt(w_rd_data[5:0]);
    assign w_is_jmp     = is_jmp(w_rd_data[5:0]);
    assign w_jmp_target = AW'(w_rd_data[3:0]);

    // A write wins over start; both are only honoured while stopped.
    assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
    assign w_load_ok   = w_idle_like && load_en;
    assign w_start_go  = w_idle_like && start && !load_en;
    assign w_fetch     = (r_state == FETCH);
    assign w_xfer      = w_valid && dec.instr_ready;

    prog_mem #(
        .DEPTH (PROG_DEPTH),
        .WIDTH (INSTR_W)
    ) u_prog_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_load_ok),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_re    (w_fetch),
        .i_raddr (r_pc),
        .o_rdata (w_rd_data)
    );

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a halt request in ISSUE waits for the pending transfer.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_start_go) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                w_state_next = halt_req ? DONE : ISSUE;
            end
            ISSUE: begin
                if (w_is_halt) begin
                    w_state_next = DONE;
                end else if (w_is_jmp || dec.instr_ready) begin
                    w_state_next = halt_req ? DONE : FETCH;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            FETCH: busy = 1'b1;
            ISSUE: begin
                busy    = 1'b1;
                w_valid = !w_is_halt && !w_is_jmp;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign dec.instr_valid = w_valid;
    assign dec.instruction = w_valid ? w_rd_data : '0;

    // Program counter update: restart, jump or advance on a transfer.
    always_comb begin
        w_pc_next = r_pc;
        if (w_start_go) begin
            w_pc_next = '0;
        end else if ((r_state == ISSUE) && w_is_jmp) begin
            w_pc_next = w_jmp_target;
        end else if (w_xfer) begin
            w_pc_next = r_pc + AW'(1);
        end
    end

    // Program counter register; the increment wraps at PROG_DEPTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

`ifdef ISSUE_CNT_EN
    logic [15:0] r_issue_count;

    // Transfer counter: cleared on every start, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_count <= '0;
        end else if (w_start_go) begin
            r_issue_count <= '0;
        end else if (w_xfer && (r_issue_count != 16'hFFFF)) begin
            r_issue_count <= r_issue_count + 16'd1;
        end
    end

    assign issue_count = r_issue_count;
`endif
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed scenarios plus randomized programs
// checked against a program-walking reference model.
module tb_instruction_sequencer;
    localparam int DEPTH = 16;
    localparam int W     = 6;
    localparam int AW    = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          halt_req  = 1'b0;
    logic          load_en   = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [W-1:0]  load_data = '0;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
`ifdef ISSUE_CNT_EN
    logic [15:0]   issue_count;
`endif

    instruction_sequencer_if #(.INSTR_W(W)) dec_if ();

    instruction_sequencer #(
        .PROG_DEPTH (DEPTH),
        .INSTR_W    (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt_req    (halt_req),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .dec         (dec_if),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
`ifdef ISSUE_CNT_EN
        ,
        .issue_count (issue_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [5:0] instr;
        logic [3:0] addr;
        int         cyc;
    } xfer_t;

    xfer_t      xfer_q[$];
    xfer_t      exp_q[$];
    logic [5:0] prog_m [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer monitor: valid && ready seen mid-cycle completes at the next edge.
    always @(negedge clk) begin
        if (rst_n && dec_if.instr_valid && dec_if.instr_ready) begin
            xfer_q.push_back('{dec_if.instruction, pc, cyc});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input int n);
        for (int i = 0; i < n; i++) begin
            load_en   = 1'b1;
            load_addr = AW'(i);
            load_data = prog_m[i];
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int max, input string tag);
        int n = 0;
        while (!dec_if.instr_valid && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(dec_if.instr_valid), 32'd1);
    endtask

    task automatic wait_done(input int max, input string tag);
        int n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // Reference: walk the program by its rules, listing every word the decoder must receive.
    function automatic void model_run();
        int p = 0;
        exp_q.delete();
        for (int steps = 0; steps < 4 * DEPTH; steps++) begin
            logic [5:0] w = prog_m[p];
            if (w == 6'b111111) break;
            if (w[5:4] == 2'b10) begin
                p = int'(w[3:0]) % DEPTH;
            end else begin
                exp_q.push_back('{w, 4'(p), 0});
                p = (p + 1) % DEPTH;
            end
        end
    endfunction

    task automatic compare_stream(input string tag);
        int n = (xfer_q.size() < exp_q.size()) ? xfer_q.size() : exp_q.size();
        check({tag, "_count"}, 32'(xfer_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < n; i++) begin
            check({tag, "_instr"}, 32'(xfer_q[i].instr), 32'(exp_q[i].instr));
            check({tag, "_pc"}, 32'(xfer_q[i].addr), 32'(exp_q[i].addr));
        end
    endtask

    function automatic logic [5:0] rand_plain_op();
        logic [5:0] op;
        do begin
            op = 6'($urandom_range(0, 63));
        end while (op == 6'b111111 || op[5:4] == 2'b10);
        return op;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_rise;
        dec_if.instr_ready = 1'b0;

        // Reset state.
        #3;
        check("rst_valid", 32'(dec_if.instr_valid), 32'd0);
        check("rst_instr", 32'(dec_if.instruction), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        #9 rst_n = 1'b1;
        tick();

        // Straight-line program ending in HALT; latency and 2-cycle cadence.
        prog_m[0] = 6'b000001; prog_m[1] = 6'b001000; prog_m[2] = 6'b111111;
        load_prog(3);
        dec_if.instr_ready = 1'b1;
        xfer_q.delete();
        do_start();
        check("lin_fetch_busy", 32'(busy), 32'd1);
        check("lin_fetch_novalid", 32'(dec_if.instr_valid), 32'd0);
        tick();
        check("lin_first_valid", 32'(dec_if.instr_valid), 32'd1);
        check("lin_first_instr", 32'(dec_if.instruction), 32'h01);
        check("lin_first_pc", 32'(pc), 32'd0);
        wait_done(20, "lin_done");
        check("lin_count", 32'(xfer_q.size()), 32'd2);
        if (xfer_q.size() == 2) begin
            check("lin_x0", 32'(xfer_q[0].instr), 32'h01);
            check("lin_x1", 32'(xfer_q[1].instr), 32'h08);
            check("lin_cadence", 32'(xfer_q[1].cyc - xfer_q[0].cyc), 32'd2);
        end
        check("lin_busy_off", 32'(busy), 32'd0);

        // JMP 0 loop: 000000 forever, pc stays in {0,1}, never done.
        prog_m[0] = 6'b000000; prog_m[1] = 6'b100000;
        load_prog(2);
        xfer_q.delete();
        do_start();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("jmp_done_low", 32'(done), 32'd0);
            check("jmp_pc_range", 32'(pc <= 4'd1), 32'd1);
        end
        check("jmp_min_xfers", 32'(xfer_q.size() >= 2), 32'd1);
        foreach (xfer_q[i]) begin
            check("jmp_instr", 32'(xfer_q[i].instr), 32'h00);
            check("jmp_pc", 32'(xfer_q[i].addr), 32'd0);
        end
        halt_req = 1'b1;
        wait_done(10, "jmp_halt_done");
        halt_req = 1'b0;

        // halt_req in FETCH stops before anything is issued.
        xfer_q.delete();
        do_start();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("fetch_halt_done", 32'(done), 32'd1);
        check("fetch_halt_noxfer", 32'(xfer_q.size()), 32'd0);

        // Stall with 111100: stable instruction/pc; a load while busy is ignored.
        prog_m[0] = 6'b111100; prog_m[1] = 6'b111111;
        load_prog(2);
        dec_if.instr_ready = 1'b0;
        xfer_q.delete();
        do_start();
        wait_valid(10, "stall_valid");
        for (int i = 0; i < 5; i++) begin
            check("stall_instr", 32'(dec_if.instruction), 32'h3C);
            check("stall_pc", 32'(pc), 32'd0);
            if (i == 0) begin
                load_en = 1'b1; load_addr = 4'd1; load_data = 6'b000001;
            end
            tick();
            load_en = 1'b0;
        end
        check("stall_still_valid", 32'(dec_if.instr_valid), 32'd1);
        dec_if.instr_ready = 1'b1;
        t_rise = cyc;
        tick();
        wait_done(10, "stall_done");
        check("stall_count", 32'(xfer_q.size()), 32'd1);
        if (xfer_q.size() >= 1) begin
            check("stall_xfer_cyc", 32'(xfer_q[0].cyc), 32'(t_rise));
            check("stall_xfer_instr", 32'(xfer_q[0].instr), 32'h3C);
        end

        // halt_req during a stalled ISSUE: the pending word still transfers.
        prog_m[0] = 6'b000001; prog_m[1] = 6'b000010; prog_m[2] = 6'b111111;
        load_prog(3);
        dec_if.instr_ready = 1'b0;
        xfer_q.delete();
        do_start();
        wait_valid(10, "hiss_valid");
        halt_req = 1'b1;
        tick();
        tick();
        check("hiss_hold_valid", 32'(dec_if.instr_valid), 32'd1);
        check("hiss_not_done", 32'(done), 32'd0);
        dec_if.instr_ready = 1'b1;
        tick();
        halt_req = 1'b0;
        check("hiss_done", 32'(done), 32'd1);
        check("hiss_count", 32'(xfer_q.size()), 32'd1);
        if (xfer_q.size() >= 1) check("hiss_instr", 32'(xfer_q[0].instr), 32'h01);

        // halt_req together with a HALT opcode.
        prog_m[0] = 6'b111111;
        load_prog(1);
        xfer_q.delete();
        do_start();
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("both_halt_done", 32'(done), 32'd1);
        check("both_halt_noxfer", 32'(xfer_q.size()), 32'd0);

        // load_en with start: the write lands, start is ignored.
        load_en = 1'b1; load_addr = 4'd0; load_data = 6'b000101; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        check("ldst_busy", 32'(busy), 32'd0);
        check("ldst_done", 32'(done), 32'd1);
        prog_m[1] = 6'b111111;
        load_en = 1'b1; load_addr = 4'd1; load_data = prog_m[1];
        tick();
        load_en = 1'b0;
        xfer_q.delete();
        do_start();
        wait_done(20, "ldst_run_done");
        check("ldst_count", 32'(xfer_q.size()), 32'd1);
        if (xfer_q.size() >= 1) check("ldst_instr", 32'(xfer_q[0].instr), 32'h05);

        // Full pass with no HALT: pc wraps 15 -> 0.
        for (int i = 0; i < DEPTH; i++) prog_m[i] = rand_plain_op();
        load_prog(DEPTH);
        dec_if.instr_ready = 1'b1;
        xfer_q.delete();
        do_start();
        for (int n = 0; n < 80 && xfer_q.size() < 16; n++) tick();
        check("wrap_reach16", 32'(xfer_q.size() >= 16), 32'd1);
`ifdef ISSUE_CNT_EN
        check("wrap_issue_count", 32'(issue_count), 32'd16);
`endif
        for (int n = 0; n < 10 && xfer_q.size() < 17; n++) tick();
        check("wrap_reach17", 32'(xfer_q.size() >= 17), 32'd1);
        for (int i = 0; i < 17 && i < xfer_q.size(); i++) begin
            check("wrap_pc", 32'(xfer_q[i].addr), 32'(i % DEPTH));
            check("wrap_instr", 32'(xfer_q[i].instr), 32'(prog_m[i % DEPTH]));
        end
        halt_req = 1'b1;
        wait_done(10, "wrap_halt_done");
        halt_req = 1'b0;

        // Asynchronous reset while stalled on the second word.
        prog_m[0] = 6'b001010; prog_m[1] = 6'b001011; prog_m[2] = 6'b111111;
        load_prog(3);
        dec_if.instr_ready = 1'b0;
        do_start();
        wait_valid(10, "arst_valid0");
        dec_if.instr_ready = 1'b1;
        tick();
        dec_if.instr_ready = 1'b0;
        tick();
        check("arst_pre_valid", 32'(dec_if.instr_valid), 32'd1);
        check("arst_pre_pc", 32'(pc), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(dec_if.instr_valid), 32'd0);
        check("arst_pc", 32'(pc), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_instr", 32'(dec_if.instruction), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        dec_if.instr_ready = 1'b1;
        xfer_q.delete();
        model_run();
        do_start();
        wait_done(20, "arst_rerun_done");
        compare_stream("arst_rerun");

        // Randomized programs (forward jumps only, HALT at the end) under random stalls.
        for (int t = 0; t < 8; t++) begin
            bit seen_done = 1'b0;
            for (int a = 0; a < DEPTH - 1; a++) begin
                int r = int'($urandom_range(0, 99));
                if (r < 15)      prog_m[a] = {2'b10, 4'($urandom_range(a + 1, DEPTH - 1))};
                else if (r < 22) prog_m[a] = 6'b111111;
                else             prog_m[a] = rand_plain_op();
            end
            prog_m[DEPTH-1] = 6'b111111;
            load_prog(DEPTH);
            model_run();
            xfer_q.delete();
            dec_if.instr_ready = ($urandom_range(0, 3) != 0);
            do_start();
            for (int n = 0; n < 300; n++) begin
                dec_if.instr_ready = ($urandom_range(0, 3) != 0);
                tick();
                if (done) begin
                    seen_done = 1'b1;
                    break;
                end
            end
            check("rand_done", 32'(seen_done), 32'd1);
            compare_stream("rand");
`ifdef ISSUE_CNT_EN
            check("rand_issue_count", 32'(issue_count), 32'(exp_q.size()));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 16: program memory depth in words (power of 2, 2..64).
REQ-002 SHALL have parameter INSTR_W, default 6: instruction width, matching the decoder's instruction input.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  level; begins execution from PC 0 when in IDLE or DONE.
REQ-006 SHALL have port halt_req  in  1  level; requests an early stop.
REQ-007 SHALL have port load_en  in  1  writes load_data to program memory at load_addr.
REQ-008 SHALL have port load_addr  in  $clog2(PROG_DEPTH)  program write address.
REQ-009 SHALL have port load_data  in  INSTR_W  program write data.
REQ-010 SHALL have port instruction  out  INSTR_W  instruction issued to the decoder.
REQ-011 SHALL have port instr_valid  out  1  instruction is valid.
REQ-012 SHALL have port instr_ready  in  1  decoder accepts; a transfer occurs on a cycle with valid && ready.
REQ-013 SHALL have port pc  out  $clog2(PROG_DEPTH)  address of the current or next fetch.
REQ-014 SHALL have port busy  out  1  high in FETCH and ISSUE.
REQ-015 SHALL have port done  out  1  high in DONE.

Function
REQ-016 SHALL implement FSM IDLE -> FETCH -> ISSUE -> (FETCH | DONE); DONE -> FETCH on start.
REQ-017 IDLE/DONE with start=1 and load_en=0 SHALL set pc=0 and enter FETCH on the next edge.
REQ-018 FETCH SHALL read the memory at pc (registered read, 1 cycle) and enter ISSUE; the first instr_valid SHALL appear 2 cycles after start is sampled.
REQ-019 Opcode 6'b111111 (HALT) SHALL NOT be issued: FSM enters DONE, valid stays 0.
REQ-020 Opcodes 2'b10 in bits [5:4] (JMP) SHALL NOT be issued: pc <= instr[3:0] mod PROG_DEPTH and FSM re-enters FETCH.
REQ-021 All other opcodes SHALL be driven on instruction with instr_valid=1 in ISSUE.
REQ-022 While valid && !ready, instruction and pc SHALL remain stable.
REQ-023 On a transfer, pc SHALL increment and the FSM SHALL enter FETCH; pc = PROG_DEPTH-1 SHALL wrap to 0.
REQ-024 halt_req in FETCH SHALL enter DONE on the next edge; in ISSUE it SHALL take effect only after the pending transfer completes (no instruction dropped).
REQ-025 halt_req and a HALT opcode in the same cycle SHALL give the same result: DONE.
REQ-026 load_en SHALL be accepted only in IDLE or DONE and ignored in FETCH/ISSUE; load_en with start in the same cycle: the write happens, start is ignored.
REQ-027 Back-to-back issue SHALL take 2 cycles per instruction (FETCH + ISSUE) when ready is held high.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, pc=0, instruction=0, instr_valid=0, busy=0, done=0; memory contents are not reset.
REQ-029 Reset mid-ISSUE SHALL drop instr_valid immediately, without waiting for the clock.

Configuration
REQ-030 With ISSUE_CNT_EN defined, an extra output issue_count (16 bits) SHALL count transfers, clear on reset and on each start, and saturate at 16'hFFFF.
REQ-031 Without ISSUE_CNT_EN, the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package seq_pkg SHALL hold the state enum (IDLE, FETCH, ISSUE, DONE), OP_HALT=6'b111111, and JMP prefix 2'b10.
REQ-033 Program storage SHALL be a sub-module prog_mem: single write port, registered read port.

Verification
REQ-034 Load [000001, 001000, 111111], start, ready=1 -> issued 000001 then 001000, done=1, exactly 2 transfers.
REQ-035 Load [000000, 100000] (JMP 0), ready=1 for 10 cycles -> 000000 issued repeatedly, pc toggles 0/1, done stays 0.
REQ-036 Hold ready=0 for 5 cycles while valid=1 with 111100 -> instruction stable at 111100 and pc unchanged; transfer occurs on the cycle ready rises.
REQ-037 Assert halt_req during ISSUE with ready=0, then raise ready -> one transfer, then DONE.
REQ-038 PROG_DEPTH=16, no HALT, ready=1 -> pc wraps 15 -> 0; with ISSUE_CNT_EN, issue_count=16 after one full pass.
REQ-039 Pulse rst_n low mid-ISSUE -> instr_valid=0 and pc=0 asynchronously; loaded program retained; start re-runs from address 0.
